// File: rtl/synth_pkg.sv
// Shared types for the polyphonic voice mixer: envelope and frame sequencer states.
// No logic, so no latency.
// No handshakes, so no backpressure.
package synth_pkg;

    typedef enum logic [1:0] {
        ENV_OFF,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    typedef enum logic [2:0] {
        MIX_IDLE,
        MIX_SCAN,
        MIX_DRAIN,
        MIX_SCALE,
        MIX_OUT
    } mix_state_t;

    localparam int VOL_MAX_DEFAULT = 4;

endpackage

// File: rtl/voice_envelope.sv
// Linear attack/release envelope step for one voice: next level and state from the current ones.
// Combinational, zero latency.
// No handshake; it is evaluated whenever the mixer processes a voice.
module voice_envelope
    import synth_pkg::*;
#(
    parameter int ENV_W = 8
) (
    input  logic [1:0]       state,
    input  logic [ENV_W-1:0] level,
    input  logic [ENV_W-1:0] attack_step,
    input  logic [ENV_W-1:0] release_step,
    output logic [1:0]       next_state,
    output logic [ENV_W-1:0] next_level
);

    localparam logic [ENV_W-1:0] ENV_MAX = {ENV_W{1'b1}};

    env_state_t       cur_st;
    env_state_t       nxt_st;
    logic [ENV_W:0]   attack_sum;

    assign cur_st     = env_state_t'(state);
    assign attack_sum = {1'b0, level} + {1'b0, attack_step};
    assign next_state = nxt_st;

    always_comb begin
        nxt_st     = cur_st;
        next_level = level;
        case (cur_st)
            ENV_ATTACK: begin
                if (attack_sum >= {1'b0, ENV_MAX}) begin
                    next_level = ENV_MAX;
                    nxt_st     = ENV_SUSTAIN;
                end else begin
                    next_level = attack_sum[ENV_W-1:0];
                end
            end
            ENV_RELEASE: begin
                if (level <= release_step) begin
                    next_level = '0;
                    nxt_st     = ENV_OFF;
                end else begin
                    next_level = level - release_step;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/poly_voice_mixer.sv
// Polyphonic voice engine: per sample tick, scan every voice through the oscillator port, envelope, mix, scale.
// out_valid lands NUM_VOICES+3 cycles after the tick cycle.
// Events are stalled (evt_ready low) while a frame runs; ticks arriving mid-frame are dropped and flagged.
module poly_voice_mixer
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 24,
    parameter int SAMPLE_W   = 32,
    parameter int PHASE_W    = 32,
    parameter int ENV_W      = 8,
    parameter int VOL_MAX    = VOL_MAX_DEFAULT,
    parameter int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clock,
    input  logic                evt_valid,
    input  logic                evt_press,
    input  logic [VIDX_W-1:0]   evt_voice,
    input  logic [PHASE_W-1:0]  evt_phase_inc,
    output logic                evt_ready,
    input  logic [ENV_W-1:0]    attack_step,
    input  logic [ENV_W-1:0]    release_step,
    input  logic [2:0]          volume,
    output logic                osc_req,
    output logic [PHASE_W-1:0]  osc_phase,
    input  logic [SAMPLE_W-1:0] osc_sample,
    output logic [SAMPLE_W-1:0] out,
    output logic                out_valid,
    output logic                busy,
    output logic [VIDX_W:0]     active_count,
    output logic                overrun
);

    localparam int ACC_W  = SAMPLE_W + VIDX_W + 1;
    localparam int PROD_W = SAMPLE_W + ENV_W + 1;
    localparam logic [VIDX_W-1:0]       LAST_IDX = VIDX_W'(NUM_VOICES - 1);
    localparam logic [VIDX_W:0]         NV_CNT   = (VIDX_W + 1)'(NUM_VOICES);
    localparam logic signed [ACC_W-1:0] NV_DIV   = ACC_W'(NUM_VOICES);
    localparam logic [2:0]              VOL_CAP  = 3'(VOL_MAX);

    mix_state_t state, state_nxt;

    logic                      prev_sc;
    logic                      tick;
    logic [VIDX_W-1:0]         scan_idx;
    logic [VIDX_W-1:0]         proc_idx;
    logic                      proc_vld;
    logic signed [ACC_W-1:0]   acc;

    logic [PHASE_W-1:0]        phase [NUM_VOICES];
    logic [PHASE_W-1:0]        inc   [NUM_VOICES];
    logic [ENV_W-1:0]          level [NUM_VOICES];
    env_state_t                vstate[NUM_VOICES];

    logic [1:0]                env_nxt_st;
    logic [ENV_W-1:0]          env_nxt_lvl;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   contrib;
    logic signed [ACC_W-1:0]   norm;
    logic signed [SAMPLE_W-1:0] norm_s;
    logic [2:0]                vol_eff;
    logic [2:0]                shamt;
    logic [VIDX_W:0]           voices_on;

    assign tick      = sample_clock & ~prev_sc;
    assign evt_ready = (state == MIX_IDLE) && !tick;
    assign busy      = (state != MIX_IDLE);
    assign osc_req   = (state == MIX_SCAN);
    assign osc_phase = osc_req ? phase[scan_idx] : '0;
    assign out_valid = (state == MIX_OUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MIX_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MIX_IDLE:  if (tick) state_nxt = MIX_SCAN;
            MIX_SCAN:  if (scan_idx == LAST_IDX) state_nxt = MIX_DRAIN;
            MIX_DRAIN: state_nxt = MIX_SCALE;
            MIX_SCALE: state_nxt = MIX_OUT;
            MIX_OUT:   state_nxt = MIX_IDLE;
            default:   state_nxt = MIX_IDLE;
        endcase
    end

    // The sample for a voice returns one cycle after its request, so processing trails scanning by one index.
    voice_envelope #(.ENV_W(ENV_W)) u_env (
        .state        (vstate[proc_idx]),
        .level        (level[proc_idx]),
        .attack_step  (attack_step),
        .release_step (release_step),
        .next_state   (env_nxt_st),
        .next_level   (env_nxt_lvl)
    );

    assign prod    = PROD_W'($signed(osc_sample)) * PROD_W'($signed({1'b0, level[proc_idx]}));
    assign contrib = (vstate[proc_idx] == ENV_OFF) ? '0 : ACC_W'(prod >>> ENV_W);

    assign norm    = acc / NV_DIV;
    assign norm_s  = SAMPLE_W'(norm);
    assign vol_eff = (volume > VOL_CAP) ? VOL_CAP : volume;
    assign shamt   = VOL_CAP - vol_eff;

    always_comb begin
        voices_on = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            voices_on = voices_on + {{VIDX_W{1'b0}}, (vstate[i] != ENV_OFF)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_sc      <= 1'b0;
            overrun      <= 1'b0;
            scan_idx     <= '0;
            proc_idx     <= '0;
            proc_vld     <= 1'b0;
            acc          <= '0;
            out          <= '0;
            active_count <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i]  <= '0;
                inc[i]    <= '0;
                level[i]  <= '0;
                vstate[i] <= ENV_OFF;
            end
        end else begin
            prev_sc  <= sample_clock;
            proc_vld <= osc_req;
            proc_idx <= scan_idx;

            if (tick && state != MIX_IDLE)
                overrun <= 1'b1;

            if (state == MIX_IDLE && tick) begin
                scan_idx <= '0;
                acc      <= '0;
            end else if (osc_req && scan_idx != LAST_IDX) begin
                scan_idx <= scan_idx + VIDX_W'(1);
            end

            // Events are only accepted in IDLE, where no voice is being processed.
            if (proc_vld) begin
                acc              <= acc + contrib;
                level[proc_idx]  <= env_nxt_lvl;
                vstate[proc_idx] <= env_state_t'(env_nxt_st);
                if (vstate[proc_idx] != ENV_OFF)
                    phase[proc_idx] <= phase[proc_idx] + inc[proc_idx];
            end else if (evt_valid && evt_ready && ({1'b0, evt_voice} < NV_CNT)) begin
                if (evt_press) begin
                    phase[evt_voice]  <= '0;
                    inc[evt_voice]    <= evt_phase_inc;
                    vstate[evt_voice] <= ENV_ATTACK;
                end else if (vstate[evt_voice] == ENV_ATTACK || vstate[evt_voice] == ENV_SUSTAIN) begin
                    vstate[evt_voice] <= ENV_RELEASE;
                end
            end

            if (state == MIX_SCALE) begin
                out          <= norm_s >>> shamt;
                active_count <= voices_on;
            end
        end
    end

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Directed bench for poly_voice_mixer: reset, frame timing, envelope mixing, volume, overrun, events, mid-frame reset.
module tb_poly_voice_mixer;

    localparam int N  = 24;
    localparam int SW = 32;
    localparam int PW = 32;
    localparam int EW = 8;
    localparam int VW = $clog2(N);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 sample_clock = 1'b0;
    logic                 evt_valid = 1'b0;
    logic                 evt_press = 1'b0;
    logic [VW-1:0]        evt_voice = '0;
    logic [PW-1:0]        evt_phase_inc = '0;
    logic                 evt_ready;
    logic [EW-1:0]        attack_step = '0;
    logic [EW-1:0]        release_step = '0;
    logic [2:0]           volume = 3'd4;
    logic                 osc_req;
    logic [PW-1:0]        osc_phase;
    logic signed [SW-1:0] osc_sample = '0;
    logic signed [SW-1:0] out;
    logic                 out_valid;
    logic                 busy;
    logic [VW:0]          active_count;
    logic                 overrun;

    int checks   = 0;
    int failures = 0;

    int                   f_lat, f_req, f_pulses, f_acc, f_rdy;
    logic [PW-1:0]        f_ph3;
    logic signed [SW-1:0] f_out;
    logic [VW:0]          f_act;

    always #5 clk = ~clk;

    poly_voice_mixer #(
        .NUM_VOICES (N),
        .SAMPLE_W   (SW),
        .PHASE_W    (PW),
        .ENV_W      (EW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sample_clock  (sample_clock),
        .evt_valid     (evt_valid),
        .evt_press     (evt_press),
        .evt_voice     (evt_voice),
        .evt_phase_inc (evt_phase_inc),
        .evt_ready     (evt_ready),
        .attack_step   (attack_step),
        .release_step  (release_step),
        .volume        (volume),
        .osc_req       (osc_req),
        .osc_phase     (osc_phase),
        .osc_sample    (osc_sample),
        .out           (out),
        .out_valid     (out_valid),
        .busy          (busy),
        .active_count  (active_count),
        .overrun       (overrun)
    );

    // One frame: tick in cycle 0, optional second tick at cycle retick_at, observe N+10 cycles.
    task automatic run_frame(input int retick_at);
        logic acc_pending;
        acc_pending = 1'b0;
        f_lat = -1; f_req = 0; f_pulses = 0; f_acc = -1; f_rdy = 0;
        f_ph3 = '1; f_out = '0; f_act = '1;
        sample_clock = 1'b1;
        #1;
        if (evt_ready) f_rdy++;
        for (int c = 1; c <= N + 10; c++) begin
            @(posedge clk); #1;
            sample_clock = (c == retick_at);
            if (acc_pending) begin
                evt_valid   = 1'b0;
                acc_pending = 1'b0;
            end
            #1;
            if (osc_req) begin
                if (f_req == 3) f_ph3 = osc_phase;
                f_req++;
            end
            if (out_valid) begin
                f_pulses++;
                if (f_lat < 0) begin
                    f_lat = c;
                    f_out = out;
                    f_act = active_count;
                end
            end
            if (evt_ready && c <= N + 3) f_rdy++;
            if (evt_valid && evt_ready) begin
                acc_pending = 1'b1;
                if (f_acc < 0) f_acc = c;
            end
        end
    endtask

    task automatic send_event(input logic press, input logic [VW-1:0] v, input logic [PW-1:0] pinc);
        int k;
        evt_valid = 1'b1; evt_press = press; evt_voice = v; evt_phase_inc = pinc;
        #1;
        k = 0;
        while (!evt_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        checks++; if (evt_ready !== 1'b1) begin failures++; $display("FAIL evt_handshake voice=%0d ready=%b exp=1", v, evt_ready); end
        @(posedge clk); #1;
        evt_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (out !== '0)          begin failures++; $display("FAIL reset_out got=%0d exp=0", out); end
        checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (evt_ready !== 1'b1)  begin failures++; $display("FAIL reset_evt_ready got=%b exp=1", evt_ready); end
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (active_count !== '0) begin failures++; $display("FAIL reset_active got=%0d exp=0", active_count); end
        checks++; if (osc_req !== 1'b0)    begin failures++; $display("FAIL reset_osc_req got=%b exp=0", osc_req); end
    endtask

    task automatic test_idle_tick();
        osc_sample = 32'sd1000;
        run_frame(0);
        checks++; if (f_lat !== N + 3)  begin failures++; $display("FAIL idle_latency got=%0d exp=%0d", f_lat, N + 3); end
        checks++; if (f_req !== N)      begin failures++; $display("FAIL idle_req_count got=%0d exp=%0d", f_req, N); end
        checks++; if (f_pulses !== 1)   begin failures++; $display("FAIL idle_pulses got=%0d exp=1", f_pulses); end
        checks++; if (f_out !== 32'sd0) begin failures++; $display("FAIL idle_out got=%0d exp=0", f_out); end
        checks++; if (f_act !== 6'd0)   begin failures++; $display("FAIL idle_active got=%0d exp=0", f_act); end
    endtask

    task automatic test_attack();
        attack_step = 8'd255; osc_sample = 32'sd24000; volume = 3'd4;
        send_event(1'b1, VW'(3), 32'h100);
        run_frame(0);
        checks++; if (f_out !== 32'sd0)    begin failures++; $display("FAIL attack_f1_out got=%0d exp=0", f_out); end
        checks++; if (f_ph3 !== 32'h0)     begin failures++; $display("FAIL attack_f1_phase got=%h exp=0", f_ph3); end
        checks++; if (f_act !== 6'd1)      begin failures++; $display("FAIL attack_f1_active got=%0d exp=1", f_act); end
        run_frame(0);
        checks++; if (f_out !== 32'sd996)  begin failures++; $display("FAIL attack_f2_out got=%0d exp=996", f_out); end
        checks++; if (f_ph3 !== 32'h100)   begin failures++; $display("FAIL attack_f2_phase got=%h exp=100", f_ph3); end
        run_frame(0);
        checks++; if (f_ph3 !== 32'h200)   begin failures++; $display("FAIL attack_f3_phase got=%h exp=200", f_ph3); end
        checks++; if (out !== 32'sd996)    begin failures++; $display("FAIL attack_out_held got=%0d exp=996", out); end
    endtask

    task automatic test_volume();
        logic [2:0]           vols [4];
        logic signed [SW-1:0] samp [4];
        logic signed [SW-1:0] expv [4];
        vols = '{3'd2, 3'd7, 3'd4, 3'd0};
        samp = '{32'sd24000, 32'sd24000, -32'sd24000, -32'sd24000};
        expv = '{32'sd249, 32'sd996, -32'sd996, -32'sd63};
        for (int i = 0; i < 4; i++) begin
            volume = vols[i]; osc_sample = samp[i];
            run_frame(0);
            checks++; if (f_out !== expv[i]) begin failures++; $display("FAIL volume_%0d got=%0d exp=%0d", i, f_out, expv[i]); end
        end
        volume = 3'd4; osc_sample = 32'sd24000;
    endtask

    task automatic test_release();
        logic signed [SW-1:0] expv [4];
        logic [VW:0]          expa [4];
        expv = '{32'sd996, 32'sd605, 32'sd214, 32'sd0};
        expa = '{6'd1, 6'd1, 6'd0, 6'd0};
        release_step = 8'd100;
        send_event(1'b0, VW'(3), 32'h0);
        for (int i = 0; i < 4; i++) begin
            run_frame(0);
            checks++; if (f_out !== expv[i]) begin failures++; $display("FAIL release_f%0d_out got=%0d exp=%0d", i, f_out, expv[i]); end
            checks++; if (f_act !== expa[i]) begin failures++; $display("FAIL release_f%0d_active got=%0d exp=%0d", i, f_act, expa[i]); end
        end
    endtask

    task automatic test_overrun_event();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_before got=%b exp=0", overrun); end
        evt_valid = 1'b1; evt_press = 1'b1; evt_voice = VW'(5); evt_phase_inc = 32'h40;
        run_frame(5);
        checks++; if (overrun !== 1'b1)   begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        checks++; if (f_pulses !== 1)     begin failures++; $display("FAIL overrun_pulses got=%0d exp=1", f_pulses); end
        checks++; if (f_lat !== N + 3)    begin failures++; $display("FAIL overrun_latency got=%0d exp=%0d", f_lat, N + 3); end
        checks++; if (f_rdy !== 0)        begin failures++; $display("FAIL busy_evt_ready cycles_high=%0d exp=0", f_rdy); end
        checks++; if (f_acc !== N + 4)    begin failures++; $display("FAIL evt_accept_cycle got=%0d exp=%0d", f_acc, N + 4); end
        checks++; if (f_out !== 32'sd0)   begin failures++; $display("FAIL overrun_out got=%0d exp=0", f_out); end
    endtask

    task automatic test_invalid_voice();
        send_event(1'b1, VW'(N), 32'h77);
        run_frame(0);
        checks++; if (f_out !== 32'sd0)   begin failures++; $display("FAIL queued_press_f1_out got=%0d exp=0", f_out); end
        checks++; if (f_act !== 6'd1)     begin failures++; $display("FAIL invalid_voice_active got=%0d exp=1", f_act); end
        run_frame(0);
        checks++; if (f_out !== 32'sd996) begin failures++; $display("FAIL queued_press_f2_out got=%0d exp=996", f_out); end
        checks++; if (f_act !== 6'd1)     begin failures++; $display("FAIL invalid_voice_active2 got=%0d exp=1", f_act); end
    endtask

    task automatic test_reset_mid_scan();
        int pulses;
        sample_clock = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            sample_clock = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got=%b exp=1", busy); end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (evt_ready !== 1'b1)  begin failures++; $display("FAIL midreset_ready got=%b exp=1", evt_ready); end
        checks++; if (out !== '0)          begin failures++; $display("FAIL midreset_out got=%0d exp=0", out); end
        checks++; if (overrun !== 1'b0)    begin failures++; $display("FAIL midreset_overrun got=%b exp=0", overrun); end
        checks++; if (active_count !== '0) begin failures++; $display("FAIL midreset_active got=%0d exp=0", active_count); end
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL midreset_pulses got=%0d exp=0", pulses); end
        run_frame(0);
        checks++; if (f_out !== 32'sd0) begin failures++; $display("FAIL midreset_frame_out got=%0d exp=0", f_out); end
        checks++; if (f_act !== 6'd0)   begin failures++; $display("FAIL midreset_frame_active got=%0d exp=0", f_act); end
    endtask

    initial begin
        test_reset();
        test_idle_tick();
        test_attack();
        test_volume();
        test_release();
        test_overrun_event();
        test_invalid_voice();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
